// File: rtl/vrf_bank_arbiter.sv
// ---------------------------------------------------------------------------
// vrf_bank_arbiter
// Round-robin arbiter that shares one dual-port vector register-file bank RAM
// among NUM_REQ lane requesters. Port A carries one read or write per cycle.
// Port B carries one extra read per cycle. Read data returns with the owning
// requester ID one cycle after the grant, which matches the RAM's registered
// output latency.
// ---------------------------------------------------------------------------
module vrf_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int AW      = 9,
  parameter int DW      = 128
) (
  input  logic                  clk,
  input  logic                  resetn,

  // Requester side
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,

  // Response side
  output logic                  rsp_a_valid,
  output logic [IDW-1:0]        rsp_a_id,
  output logic [DW-1:0]         rsp_a_data,
  output logic                  rsp_b_valid,
  output logic [IDW-1:0]        rsp_b_id,
  output logic [DW-1:0]         rsp_b_data,

  // RAM wrapper side
  output logic [AW-1:0]         ram_address_a,
  output logic                  ram_wren_a,
  output logic [DW-1:0]         ram_data_a,
  output logic                  ram_rden_a,
  output logic [AW-1:0]         ram_address_b,
  output logic                  ram_rden_b,
  output logic                  ram_wren_b,
  output logic [DW-1:0]         ram_data_b,
  input  logic [DW-1:0]         ram_out_a,
  input  logic [DW-1:0]         ram_out_b
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr_q,      rr_ptr_d;
  logic           rsp_a_valid_q, rsp_a_valid_d;
  logic [IDW-1:0] rsp_a_id_q,    rsp_a_id_d;
  logic           rsp_b_valid_q, rsp_b_valid_d;
  logic [IDW-1:0] rsp_b_id_q,    rsp_b_id_d;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [AW-1:0]  addr_s  [NUM_REQ];
  logic [DW-1:0]  wdata_s [NUM_REQ];

  logic           w0_found_s;
  logic [IDW-1:0] w0_idx_s;
  logic           w0_we_s;
  logic           w1_found_s;
  logic [IDW-1:0] w1_idx_s;
  logic           hazard_s;
  logic           w1_grant_s;

  // Split the packed request buses into per-requester address and data
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_s[i]  = req_addr[i*AW +: AW];
      wdata_s[i] = req_wdata[i*DW +: DW];
    end
  end

  // Round-robin search from rr_ptr. W0 is the first valid requester.
  // W1 is the first valid read that comes strictly after W0 in the same order.
  always_comb begin
    logic           seen0_v;
    logic           seen1_v;
    logic           sel0_v;
    logic           sel1_v;
    logic [IDW-1:0] ord_v;
    seen0_v  = 1'b0;
    seen1_v  = 1'b0;
    sel0_v   = 1'b0;
    sel1_v   = 1'b0;
    ord_v    = {IDW{1'b0}};
    w0_idx_s = {IDW{1'b0}};
    w1_idx_s = {IDW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      // The requester count is a power of two, so the wrap is free.
      ord_v    = rr_ptr_q + IDW'(k);
      sel0_v   = req_valid[ord_v] & ~seen0_v;
      // W1 must come after W0, so only seen0_v from earlier positions counts.
      sel1_v   = req_valid[ord_v] & ~req_we[ord_v] & seen0_v & ~seen1_v;
      w0_idx_s = w0_idx_s | (sel0_v ? ord_v : {IDW{1'b0}});
      w1_idx_s = w1_idx_s | (sel1_v ? ord_v : {IDW{1'b0}});
      seen0_v  = seen0_v | sel0_v;
      seen1_v  = seen1_v | sel1_v;
    end
    w0_found_s = seen0_v;
    w1_found_s = seen1_v;
  end

  // Decide whether W1 actually gets port B.
  // A port-B read of the address being written on port A is held for a cycle,
  // so that it sees the new data instead of racing the write.
  always_comb begin
    w0_we_s    = w0_found_s & req_we[w0_idx_s];
    hazard_s   = w0_we_s & w1_found_s & (addr_s[w1_idx_s] == addr_s[w0_idx_s]);
    w1_grant_s = w1_found_s & ~hazard_s;
  end

  // Drive the grant acknowledges. All acks are forced low while in reset.
  always_comb begin
    req_ack = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ack[i] = resetn &
                   ((w0_found_s & (w0_idx_s == IDW'(i))) |
                    (w1_grant_s & (w1_idx_s == IDW'(i))));
    end
  end

  // Drive the RAM ports. Port B is read-only, so its write side is tied off.
  always_comb begin
    ram_address_a = addr_s[w0_idx_s];
    ram_data_a    = wdata_s[w0_idx_s];
    ram_wren_a    = resetn & w0_we_s;
    ram_rden_a    = resetn & w0_found_s & ~w0_we_s;
    // When rden_b is low, the wrapper ignores this address.
    ram_address_b = addr_s[w1_idx_s];
    ram_rden_b    = resetn & w1_grant_s;
    ram_wren_b    = 1'b0;
    ram_data_b    = {DW{1'b0}};
  end

  // Next-state logic for the pointer and the response tags.
  // The pointer moves past the last requester served. It holds while idle.
  always_comb begin
    rr_ptr_d      = w0_found_s ?
                    ((w1_grant_s ? w1_idx_s : w0_idx_s) + {{(IDW-1){1'b0}}, 1'b1}) :
                    rr_ptr_q;
    rsp_a_valid_d = w0_found_s & ~w0_we_s;
    rsp_a_id_d    = w0_idx_s;
    rsp_b_valid_d = w1_grant_s;
    rsp_b_id_d    = w1_idx_s;
  end

  // Registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q      <= {IDW{1'b0}};
      rsp_a_valid_q <= 1'b0;
      rsp_a_id_q    <= {IDW{1'b0}};
      rsp_b_valid_q <= 1'b0;
      rsp_b_id_q    <= {IDW{1'b0}};
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_a_valid_q <= rsp_a_valid_d;
      rsp_a_id_q    <= rsp_a_id_d;
      rsp_b_valid_q <= rsp_b_valid_d;
      rsp_b_id_q    <= rsp_b_id_d;
    end
  end

  // Response outputs. Data passes straight through from the RAM's registered outputs.
  always_comb begin
    rsp_a_valid = rsp_a_valid_q;
    rsp_a_id    = rsp_a_id_q;
    rsp_a_data  = ram_out_a;
    rsp_b_valid = rsp_b_valid_q;
    rsp_b_id    = rsp_b_id_q;
    rsp_b_data  = ram_out_b;
  end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vrf_bank_arbiter
// Directed and randomized bench for vrf_bank_arbiter. The bench has three parts:
// - a behavioural dual-port RAM with registered outputs;
// - a list-based round-robin reference model;
// - a shadow memory that supplies the expected read data.
// ---------------------------------------------------------------------------
module tb_vrf_bank_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int AW  = 9;
  localparam int DW  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic [NR-1:0]     req_valid, req_we, req_ack;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic              rsp_a_valid, rsp_b_valid;
  logic [IDW-1:0]    rsp_a_id, rsp_b_id;
  logic [DW-1:0]     rsp_a_data, rsp_b_data;
  logic [AW-1:0]     ram_address_a, ram_address_b;
  logic              ram_wren_a, ram_rden_a, ram_rden_b, ram_wren_b;
  logic [DW-1:0]     ram_data_a, ram_data_b;
  logic [DW-1:0]     ram_out_a, ram_out_b;

  vrf_bank_arbiter #(.NUM_REQ(NR), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_a_valid(rsp_a_valid), .rsp_a_id(rsp_a_id), .rsp_a_data(rsp_a_data),
    .rsp_b_valid(rsp_b_valid), .rsp_b_id(rsp_b_id), .rsp_b_data(rsp_b_data),
    .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a),
    .ram_data_a(ram_data_a), .ram_rden_a(ram_rden_a),
    .ram_address_b(ram_address_b), .ram_rden_b(ram_rden_b),
    .ram_wren_b(ram_wren_b), .ram_data_b(ram_data_b),
    .ram_out_a(ram_out_a), .ram_out_b(ram_out_b)
  );

  // Behavioural bank RAM. Reads return the old contents and are registered.
  logic [DW-1:0] mem     [512];
  logic [DW-1:0] ref_mem [512];
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_rden_a) ram_out_a <= mem[ram_address_a];
    if (ram_rden_b) ram_out_b <= mem[ram_address_b];
  end

  // Requester state and reference model state
  bit            pv  [NR];
  bit            pwe [NR];
  logic [AW-1:0] paddr [NR];
  logic [DW-1:0] pwd [NR];
  int            m_ptr;
  bit            m_rv_a, m_rv_b;
  int            m_id_a, m_id_b;
  logic [DW-1:0] m_d_a, m_d_b;
  logic [NR-1:0] obs_ack;
  bit            rnd_mode;
  int            ack_cnt [NR];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pv[i];
      req_we[i]              = pwe[i];
      req_addr[i*AW +: AW]   = paddr[i];
      req_wdata[i*DW +: DW]  = pwd[i];
    end
  endtask

  task automatic new_req(input int i);
    pv[i]    = 1'b1;
    pwe[i]   = ($urandom_range(0, 2) == 0);
    paddr[i] = AW'($urandom_range(0, 7));
    pwd[i]   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference pick.
  // Build the search order as a list starting at the pointer.
  // W0 is the first valid entry. W1 is the first later entry that is a read.
  // W1 is dropped if it targets the address that W0 is writing.
  task automatic model_pick(output int w0, output int w1);
    int order[$];
    int pos0;
    w0 = -1; w1 = -1; pos0 = -1;
    for (int k = 0; k < NR; k++) order.push_back((m_ptr + k) % NR);
    foreach (order[p]) if (w0 < 0 && pv[order[p]]) begin w0 = order[p]; pos0 = p; end
    if (w0 >= 0)
      foreach (order[p]) if (p > pos0 && w1 < 0 && pv[order[p]] && !pwe[order[p]]) w1 = order[p];
    if (w0 >= 0 && w1 >= 0)
      if (pwe[w0] && paddr[w1] == paddr[w0]) w1 = -1;
  endtask

  // One cycle. The task is entered at a negedge.
  // It drives the inputs, checks the outputs, and then advances the model at the posedge.
  task automatic do_cycle();
    int w0, w1;
    bit w0we;
    logic [NR-1:0] eack;
    drive();
    #1;
    w0 = -1; w1 = -1;
    if (resetn) model_pick(w0, w1);
    w0we = (w0 >= 0) ? pwe[w0] : 1'b0;
    eack = '0;
    if (w0 >= 0) eack[w0] = 1'b1;
    if (w1 >= 0) eack[w1] = 1'b1;
    obs_ack = req_ack;
    for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
    chk("ack", DW'(req_ack), DW'(eack));
    chk("wren_a", DW'(ram_wren_a), DW'(w0we));
    chk("rden_a", DW'(ram_rden_a), DW'((w0 >= 0) && !w0we));
    chk("rden_b", DW'(ram_rden_b), DW'(w1 >= 0));
    chk("wren_b", DW'(ram_wren_b), DW'(1'b0));
    if (w0 >= 0) chk("addr_a", DW'(ram_address_a), DW'(paddr[w0]));
    if (w0we)    chk("data_a", ram_data_a, pwd[w0]);
    if (w1 >= 0) chk("addr_b", DW'(ram_address_b), DW'(paddr[w1]));
    chk("rsp_a_valid", DW'(rsp_a_valid), DW'(m_rv_a));
    if (m_rv_a) begin
      chk("rsp_a_id", DW'(rsp_a_id), DW'(m_id_a));
      chk("rsp_a_data", rsp_a_data, m_d_a);
    end
    chk("rsp_b_valid", DW'(rsp_b_valid), DW'(m_rv_b));
    if (m_rv_b) begin
      chk("rsp_b_id", DW'(rsp_b_id), DW'(m_id_b));
      chk("rsp_b_data", rsp_b_data, m_d_b);
    end
    @(posedge clk);
    if (resetn) begin
      m_rv_a = (w0 >= 0) && !w0we;
      m_id_a = w0;
      if (m_rv_a) m_d_a = ref_mem[paddr[w0]];
      m_rv_b = (w1 >= 0);
      m_id_b = w1;
      if (m_rv_b) m_d_b = ref_mem[paddr[w1]];
      if (w0we) ref_mem[paddr[w0]] = pwd[w0];
      if (w0 >= 0) m_ptr = (((w1 >= 0) ? w1 : w0) + 1) % NR;
      if (w0 >= 0) pv[w0] = 1'b0;
      if (w1 >= 0) pv[w1] = 1'b0;
    end else begin
      m_rv_a = 1'b0;
      m_rv_b = 1'b0;
      m_ptr  = 0;
    end
    @(negedge clk);
  endtask

  task automatic one_read(input int i, input int a);
    pv[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = AW'(a);
    do_cycle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[5]     = {16{8'hAA}};
    ref_mem[5] = {16{8'hAA}};
    ram_out_a = '0; ram_out_b = '0;
    m_ptr = 0; m_rv_a = 0; m_rv_b = 0; m_id_a = 0; m_id_b = 0;
    m_d_a = '0; m_d_b = '0; rnd_mode = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i] = 0;
      new_req(i);
    end

    // Reset held with all requesters valid
    resetn = 1'b0;
    drive();
    @(negedge clk);
    do_cycle();
    do_cycle();
    chk("rst_id_a", DW'(rsp_a_id), DW'(0));
    chk("rst_id_b", DW'(rsp_b_id), DW'(0));
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    resetn = 1'b1;
    do_cycle();

    // Single read by requester 2 of address 0x05
    one_read(2, 5);
    chk("single_ack", DW'(obs_ack), DW'(4'b0100));
    one_read(3, 8'h30);                      // moves the pointer back to 0

    // Dual read with the pointer at 0
    pv[0] = 1'b1; pwe[0] = 1'b0; paddr[0] = 9'h010;
    pv[3] = 1'b1; pwe[3] = 1'b0; paddr[3] = 9'h011;
    do_cycle();
    chk("dual_ack", DW'(obs_ack), DW'(4'b1001));
    one_read(0, 8'h31);                      // pointer now 1

    // Write/read hazard on 0x20
    pv[1] = 1'b1; pwe[1] = 1'b1; paddr[1] = 9'h020; pwd[1] = {4{32'h1234_5678}};
    pv[2] = 1'b1; pwe[2] = 1'b0; paddr[2] = 9'h020;
    do_cycle();
    chk("hazard_ack", DW'(obs_ack), DW'(4'b0010));
    do_cycle();                              // requester 2 retries and gets port A
    chk("hazard_retry_ack", DW'(obs_ack), DW'(4'b0100));
    one_read(3, 8'h32);                      // checks the new data and sets the pointer to 0

    // Fairness: all four requesters read continuously for 8 cycles
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NR; i++) begin
        pv[i] = 1'b1; pwe[i] = 1'b0; paddr[i] = AW'($urandom_range(64, 127));
      end
      do_cycle();
      chk("fair_pair", DW'(obs_ack), DW'((c % 2 == 0) ? 4'b0011 : 4'b1100));
    end
    for (int i = 0; i < NR; i++) chk("fair_count", DW'(ack_cnt[i]), DW'(4));

    // Two writers: only port A is ever used
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 2; i++) begin
        pv[i] = 1'b1; pwe[i] = 1'b1; paddr[i] = AW'(9'h040 + i);
        pwd[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      do_cycle();
      chk("wr_only_ack", DW'(obs_ack), DW'((c % 2 == 0) ? 4'b0001 : 4'b0010));
    end
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    do_cycle();

    // Randomized traffic, with a reset pulse in the middle
    rnd_mode = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) if (!pv[i] && $urandom_range(0, 1) == 1) new_req(i);
      resetn = !(c == 150 || c == 151);
      do_cycle();
    end
    resetn = 1'b1;
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
    do_cycle();
    do_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
